// File: rtl/sensor_pattern_tx.sv
// Camera-sensor emulator that drives a parallel pixel interface (pclk, FV, LV, 8-bit data)
// with timed frames carrying selectable test patterns; all outputs change on pclk falling edges.
`timescale 1ns/1ps
module sensor_pattern_tx #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 320,
  parameter int H_BLANK     = 16,
  parameter int V_BLANK_FOT = 8,
  parameter int V_GAP       = 32,
  parameter int CLK_DIV     = 2,
  parameter int FCNT_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic              clk_out,
  output logic              frame_vaild,
  output logic              line_vaild,
  output logic [7:0]        data_out,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FOT_HEAD, LINE, ROT, FOT_TAIL, GAP} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = 16;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] FOT_LAST = CW'(V_BLANK_FOT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(V_GAP - 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              clk_q, clk_d;
  logic              tick;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     row_q, row_d;
  logic [1:0]        pat_q, pat_d;
  logic              fv_q, fv_d;
  logic              lv_q, lv_d;
  logic              busy_q, busy_d;
  logic [7:0]        data_q, data_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  function automatic logic [7:0] pixel(input logic [1:0] sel, input logic [7:0] col,
                                       input logic [7:0] row);
    case (sel)
      2'd0:    return col;
      2'd1:    return row;
      2'd2:    return col + row;
      default: return {8{col[3] ^ row[3]}};
    endcase
  endfunction

  always_comb begin
    tick    = (div_q == DIV_LAST) && clk_q;
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    clk_d   = (div_q == DIV_LAST) ? ~clk_q : clk_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    pat_d   = pat_q;
    busy_d  = busy_q;
    fcnt_d  = fcnt_q;
    fv_d    = fv_q;
    lv_d    = lv_q;
    data_d  = data_q;
    if (tick) begin
      case (state_q)
        IDLE: if (enable) begin
          state_d = FOT_HEAD;
          pat_d   = pattern_sel;
          busy_d  = 1'b1;
        end
        FOT_HEAD: if (cnt_q == FOT_LAST) begin
          state_d = LINE;
          cnt_d   = '0;
          row_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        LINE: if (cnt_q == H_LAST) begin
          state_d = (row_q == V_LAST) ? FOT_TAIL : ROT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
        ROT: if (cnt_q == HB_LAST) begin
          state_d = LINE;
          cnt_d   = '0;
          row_d   = row_q + CW'(1);
        end else cnt_d = cnt_q + CW'(1);
        FOT_TAIL: if (cnt_q == FOT_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          fcnt_d  = fcnt_q + FCNT_W'(1);
        end else cnt_d = cnt_q + CW'(1);
        GAP: if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (enable) begin
            state_d = FOT_HEAD;
            pat_d   = pattern_sel;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else cnt_d = cnt_q + CW'(1);
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
      // Outputs follow the state being entered so they hold for the whole pclk period.
      fv_d   = state_d inside {FOT_HEAD, LINE, ROT, FOT_TAIL};
      lv_d   = (state_d == LINE);
      data_d = (state_d == LINE) ? pixel(pat_d, cnt_d[7:0], row_d[7:0]) : 8'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      clk_q   <= 1'b0;
      cnt_q   <= '0;
      row_q   <= '0;
      pat_q   <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign clk_out     = clk_q;
  assign frame_vaild = fv_q;
  assign line_vaild  = lv_q;
  assign data_out    = data_q;
  assign frame_cnt   = fcnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sensor_pattern_tx.sv
// Bench for sensor_pattern_tx: a frame-position model checks two instances (4- and 16-pixel
// lines) every sys_clk, and directed frame captures pin timing and pattern values.
`timescale 1ns/1ps
module tb_sensor_pattern_tx;
  localparam int HA = 4, HA16 = 16, VA = 3, HB = 2, FOT = 3, VG = 5, CD = 2, FW = 2;

  logic          sys_clk = 1'b0, sys_rst_n = 1'b0, enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          clk_out, fv, lv, busy;
  logic [7:0]    data;
  logic [FW-1:0] fcnt;
  logic          clk_out16, fv16, lv16, busy16;
  logic [7:0]    data16;
  logic [FW-1:0] fcnt16;

  sensor_pattern_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK_FOT(FOT),
                      .V_GAP(VG), .CLK_DIV(CD), .FCNT_W(FW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .clk_out(clk_out), .frame_vaild(fv), .line_vaild(lv), .data_out(data),
    .frame_cnt(fcnt), .busy(busy));

  sensor_pattern_tx #(.H_ACTIVE(HA16), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK_FOT(FOT),
                      .V_GAP(VG), .CLK_DIV(CD), .FCNT_W(FW)) dut16 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .clk_out(clk_out16), .frame_vaild(fv16), .line_vaild(lv16), .data_out(data16),
    .frame_cnt(fcnt16), .busy(busy16));

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0, shown = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: position inside the frame period ----------------
  function automatic int hlen(input int k);
    return (k == 0) ? HA : HA16;
  endfunction
  function automatic int body(input int h);
    return VA * h + (VA - 1) * HB;
  endfunction
  function automatic logic [7:0] pix(input logic [1:0] s, input int c, input int r);
    logic [7:0] cc, rr;
    cc = c[7:0];
    rr = r[7:0];
    case (s)
      2'd0:    return cc;
      2'd1:    return rr;
      2'd2:    return cc + rr;
      default: return {8{cc[3] ^ rr[3]}};
    endcase
  endfunction
  // {fv, lv, data} for pclk number p of a frame (0 = first FOT pclk)
  function automatic logic [9:0] sym(input int p, input int h, input logic [1:0] s);
    int q;
    q = p;
    if (q < FOT) return {2'b10, 8'd0};
    q = q - FOT;
    if (q < body(h)) begin
      if ((q % (h + HB)) < h) return {2'b11, pix(s, q % (h + HB), q / (h + HB))};
      return {2'b10, 8'd0};
    end
    q = q - body(h);
    if (q < FOT) return {2'b10, 8'd0};
    return 10'd0;
  endfunction

  int            sc;
  logic          m_clk;
  int            pos[2];
  logic          act[2];
  logic [1:0]    msel[2];
  logic [9:0]    m_sym[2];
  logic          m_busy[2];
  logic [FW-1:0] m_fcnt[2];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sc    <= 0;
      m_clk <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        pos[k] <= 0; act[k] <= 1'b0; msel[k] <= 2'd0;
        m_sym[k] <= 10'd0; m_busy[k] <= 1'b0; m_fcnt[k] <= '0;
      end
    end else begin
      sc    <= sc + 1;
      m_clk <= (((sc + 1) / CD) % 2) == 1;
      if (((sc + 1) % (2 * CD)) == 0) begin
        for (int k = 0; k < 2; k++) begin
          if (act[k] && (pos[k] + 1 < 2 * FOT + body(hlen(k)) + VG)) begin
            pos[k]   <= pos[k] + 1;
            m_sym[k] <= sym(pos[k] + 1, hlen(k), msel[k]);
            if (pos[k] + 1 == 2 * FOT + body(hlen(k))) m_fcnt[k] <= m_fcnt[k] + 1'b1;
          end else if (enable) begin
            act[k] <= 1'b1; pos[k] <= 0; msel[k] <= pattern_sel;
            m_sym[k] <= sym(0, hlen(k), pattern_sel); m_busy[k] <= 1'b1;
          end else begin
            act[k] <= 1'b0; pos[k] <= 0; m_sym[k] <= 10'd0; m_busy[k] <= 1'b0;
          end
        end
      end
    end
  end

  initial begin : compare
    logic [13:0] got, want;
    forever begin
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        got  = (k == 0) ? {clk_out, fv, lv, data, busy, fcnt}
                        : {clk_out16, fv16, lv16, data16, busy16, fcnt16};
        want = {m_clk, m_sym[k], m_busy[k], m_fcnt[k]};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          if (shown < 10)
            $display("FAIL model_cycle dut%0d t=%0t: got clk/fv/lv/data/busy/fcnt=%h, expected %h",
                     k, $time, got, want);
          shown++;
        end
      end
    end
  end

  // ---------------- directed capture ----------------
  logic s_fv, s_lv, s_busy, s_lv16;
  logic [7:0] s_d, s_d16;
  logic [FW-1:0] s_fcnt;
  int r_fv, r_head, r_lines, r_rot, r_tail, r_gap, r_fcnt, r_busy, n16;
  int r_data[3][4];
  int r_lvlen[3];
  int r16[16];

  // one sample per pclk rising edge, taken on the following sys_clk falling edge
  task automatic sample();
    int g;
    g = 0;
    @(negedge sys_clk);
    while (clk_out !== 1'b0 && g < 20) begin @(negedge sys_clk); g++; end
    while (clk_out !== 1'b1 && g < 40) begin @(negedge sys_clk); g++; end
    if (clk_out !== 1'b1) chk("pclk_timeout", int'(clk_out), 1);
    s_fv = fv; s_lv = lv; s_d = data; s_busy = busy; s_fcnt = fcnt;
    s_lv16 = lv16; s_d16 = data16;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    s_fv = 1'b0; s_lv = 1'b0; s_busy = 1'b0;
  endtask

  // capture one frame plus its trailing gap; drop enable at the start of line drop_row
  task automatic grab_frame(input int drop_row, input logic [1:0] new_sel);
    int g, pend, li;
    logic prev_lv;
    r_fv = 0; r_head = 0; r_lines = 0; r_rot = 0; r_tail = 0; r_gap = 0; n16 = 0;
    pend = 0; g = 0; prev_lv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_lvlen[i] = 0;
      for (int j = 0; j < 4; j++) r_data[i][j] = -1;
    end
    while (!s_fv && g < 200) begin sample(); g++; end
    if (!s_fv) chk("frame_start_timeout", int'(s_fv), 1);
    while (s_fv && g < 400) begin
      r_fv++;
      if (s_lv) begin
        if (!prev_lv) begin
          if (r_lines > 0) r_rot += pend;
          pend = 0;
          r_lines++;
          if (r_lines - 1 == drop_row) begin enable = 1'b0; pattern_sel = new_sel; end
        end
        li = r_lines - 1;
        if (li < 3) begin
          if (r_lvlen[li] < 4) r_data[li][r_lvlen[li]] = int'(s_d);
          r_lvlen[li]++;
        end
      end else if (r_lines == 0) r_head++;
      else pend++;
      if (s_lv16 && n16 < 16) begin r16[n16] = int'(s_d16); n16++; end
      prev_lv = s_lv;
      sample(); g++;
    end
    r_tail = pend;
    r_fcnt = int'(s_fcnt);
    while (!s_fv && s_busy && g < 500) begin
      r_gap++; r_fcnt = int'(s_fcnt);
      sample(); g++;
    end
    r_busy = int'(s_busy);
  endtask

  task automatic chk_line(input string name, input int l, input int d0, input int step);
    for (int c = 0; c < 4; c++) chk(name, r_data[l][c], d0 + step * c);
  endtask

  task automatic chk_shape(input string tag);
    chk({tag, "_fv_len"}, r_fv, 22);
    chk({tag, "_head"}, r_head, 3);
    chk({tag, "_lines"}, r_lines, 3);
    chk({tag, "_rot_total"}, r_rot, 4);
    chk({tag, "_tail"}, r_tail, 3);
    for (int i = 0; i < 3; i++) chk({tag, "_lv_len"}, r_lvlen[i], 4);
    chk({tag, "_gap"}, r_gap, 5);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    time t0;
    int ef[5];
    ef = '{1, 2, 3, 0, 1};
    s_fv = 1'b0; s_lv = 1'b0; s_busy = 1'b0;

    // idle after reset: pclk runs, everything else quiet
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    chk("idle_fv", int'(fv), 0);
    chk("idle_lv", int'(lv), 0);
    chk("idle_data", int'(data), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_fcnt", int'(fcnt), 0);
    sample();
    t0 = $time;
    sample();
    chk("pclk_period_sysclk", int'(($time - t0) / 10), 4);

    // column ramp, single frame
    pattern_sel = 2'd0; enable = 1'b1;
    grab_frame(0, 2'd0);
    chk_shape("colramp");
    for (int l = 0; l < 3; l++) chk_line("colramp_data", l, 0, 1);
    chk("colramp_fcnt", r_fcnt, 1);
    chk("colramp_busy_after", r_busy, 0);

    // diagonal
    do_reset();
    pattern_sel = 2'd2; enable = 1'b1;
    grab_frame(0, 2'd2);
    chk_line("diag_line0", 0, 0, 1);
    chk_line("diag_line1", 1, 1, 1);
    chk_line("diag_line2", 2, 2, 1);

    // checker on the 16-pixel instance
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    grab_frame(0, 2'd3);
    chk("checker16_count", n16, 16);
    for (int i = 0; i < 16; i++) chk("checker16_data", r16[i], (i < 8) ? 0 : 255);
    chk_line("checker4_line0", 0, 0, 0);

    // enable and pattern change during line 1 take effect only after the frame
    do_reset();
    pattern_sel = 2'd1; enable = 1'b1;
    grab_frame(1, 2'd2);
    chk_shape("drop");
    for (int l = 0; l < 3; l++) chk_line("rowramp_data", l, l, 0);
    chk("drop_fcnt", r_fcnt, 1);
    chk("drop_busy_after", r_busy, 0);
    enable = 1'b1;
    grab_frame(0, 2'd2);
    chk_line("newsel_line1", 1, 1, 1);
    chk("newsel_fcnt", r_fcnt, 2);

    // asynchronous reset in the middle of a line
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    for (int g = 0; g < 100 && !s_lv; g++) sample();
    chk("midline_reached", int'(s_lv), 1);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_fv", int'(fv), 0);
    chk("rst_lv", int'(lv), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_fcnt", int'(fcnt), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    s_fv = 1'b0; s_lv = 1'b0; s_busy = 1'b0;
    grab_frame(0, 2'd0);
    chk_shape("restart");
    chk_line("restart_line0", 0, 0, 1);
    chk("restart_fcnt", r_fcnt, 1);

    // continuous streaming, frame counter wraps at 2 bits
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      grab_frame(-1, 2'd0);
      chk("stream_fv_len", r_fv, 22);
      chk("stream_gap", r_gap, 5);
      chk("stream_fcnt", r_fcnt, ef[i]);
    end
    enable = 1'b0;
    repeat (300) @(negedge sys_clk);
    chk("final_busy", int'(busy), 0);
    chk("final_fv", int'(fv), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
